// File: rtl/simple_risc_fetch_queue.sv
// simple_risc_fetch_queue
// Instruction-fetch front end: issues word addresses into a one-cycle-latency
// instruction memory, queues returned words with their next-PC in a small
// prefetch FIFO, hands entries to decode over valid/ready, flushes on branch
// redirect and parks after an HLT opcode is fetched.
// Optional feature macro: FETCH_BYPASS_EN -- when defined, a response arriving
// while the FIFO is empty is presented on the outputs in the same cycle.
module simple_risc_fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              AW       = 10,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic               clk1,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [AW-1:0]      imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [AW-1:0]      redirect_pc,
    output logic               out_valid,
    output logic [31:0]        out_instr,
    output logic [AW-1:0]      out_npc,
    input  logic               out_ready,
    output logic               fetch_parked
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] r_pc;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic          r_inflight;
    logic [AW-1:0] r_inflight_npc;
    logic          r_drop;
    logic          r_parked;
    logic          r_active;     // low during reset and until the first edge after release

    logic [31:0]   r_fifo_instr [DEPTH];
    logic [AW-1:0] r_fifo_npc   [DEPTH];

    logic [CW-1:0] w_occ;
    logic          w_req;
    logic          w_resp_keep;
    logic          w_is_hlt;
    logic          w_empty;
    logic          w_bypass;
    logic          w_out_valid;
    logic          w_pop;
    logic          w_fifo_pop;
    logic          w_push;

    // The in-flight word always has a reserved slot, so occupancy counts it.
    assign w_occ       = r_count + CW'(r_inflight);
    assign w_req       = r_active && !r_parked && !redirect_valid && (w_occ < CW'(DEPTH));
    // A response that lands in a redirect cycle belongs to the old path.
    assign w_resp_keep = r_inflight && !r_drop && !redirect_valid;
    assign w_is_hlt    = (imem_rdata[31:27] == 5'b10000);
    assign w_empty     = (r_count == '0);

`ifdef FETCH_BYPASS_EN
    assign w_bypass    = w_resp_keep && w_empty;
`else
    assign w_bypass    = 1'b0;
`endif

    assign w_out_valid = !redirect_valid && (!w_empty || w_bypass);
    assign w_pop       = w_out_valid && out_ready;
    assign w_fifo_pop  = w_pop && !w_empty;
    // A bypassed word that decode takes immediately never enters the FIFO.
    assign w_push      = w_resp_keep && !(w_bypass && out_ready);

    assign imem_req     = w_req;
    assign imem_addr    = r_pc;
    assign out_valid    = w_out_valid;
    assign fetch_parked = r_parked;

    // Output data: FIFO head, or the live response when bypassing; zero when idle.
    always_comb begin
        out_instr = '0;
        out_npc   = '0;
        if (w_out_valid) begin
            if (w_empty) begin
                out_instr = imem_rdata;
                out_npc   = r_inflight_npc;
            end else begin
                out_instr = r_fifo_instr[r_rd_ptr];
                out_npc   = r_fifo_npc[r_rd_ptr];
            end
        end
    end

    // Fetch-side state: PC, in-flight tag, drop flag and park flag.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_active       <= 1'b0;
            r_pc           <= RESET_PC;
            r_inflight     <= 1'b0;
            r_inflight_npc <= '0;
            r_drop         <= 1'b0;
            r_parked       <= 1'b0;
        end else begin
            r_active   <= 1'b1;
            r_inflight <= w_req;
            r_drop     <= redirect_valid && r_inflight;
            if (w_req) begin
                r_inflight_npc <= r_pc + 1'b1;
            end
            if (redirect_valid) begin
                r_pc     <= redirect_pc;
                r_parked <= 1'b0;
            end else begin
                if (w_req) begin
                    r_pc <= r_pc + 1'b1;
                end
                if (w_resp_keep && w_is_hlt) begin
                    r_parked <= 1'b1;
                end
            end
        end
    end

    // FIFO bookkeeping: pointers and occupancy, cleared by a redirect.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (redirect_valid) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_fifo_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_fifo_pop);
        end
    end

    // FIFO storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk1) begin
        if (w_push && !redirect_valid) begin
            r_fifo_instr[r_wr_ptr] <= imem_rdata;
            r_fifo_npc[r_wr_ptr]   <= r_inflight_npc;
        end
    end

endmodule

// File: tb/tb_simple_risc_fetch_queue.sv
// Testbench for simple_risc_fetch_queue: behavioural instruction memory plus
// a scoreboard of expected {instr, npc} entries consumed at each transfer.
module tb_simple_risc_fetch_queue;

    localparam int AW    = 10;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk1;
    logic          rst_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_npc;
    logic          out_ready;
    logic          fetch_parked;

    typedef struct packed {
        logic [31:0]   instr;
        logic [AW-1:0] npc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [1024];
    int          n_checks;
    int          n_fail;

    simple_risc_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC('0)) dut (
        .clk1          (clk1),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_npc       (out_npc),
        .out_ready     (out_ready),
        .fetch_parked  (fetch_parked)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Instruction memory with one-cycle read latency.
    always @(posedge clk1) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
        else          imem_rdata <= 32'h0BAD_0BAD;
    end

    task automatic fill_mem();
        for (int i = 0; i < 1024; i++) mem[i] = {5'b00000, 27'(i * 13 + 5)};
    endtask

    task automatic push_exp(input int a);
        exp_t e;
        e.instr = mem[a];
        e.npc   = AW'(a + 1);
        exp_q.push_back(e);
    endtask

    // Leaves the bench at the negedge of cycle 1 after reset release.
    task automatic apply_reset();
        @(negedge clk1);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        exp_q.delete();
        @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b required 0", imem_req); end
        n_checks++;
        if (out_valid !== 1'b0 || fetch_parked !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got valid=%b parked=%b required 0 0", out_valid, fetch_parked);
        end
        n_checks++;
        if (imem_addr !== 10'h000 || out_instr !== 32'h0 || out_npc !== 10'h000) begin
            n_fail++; $display("FAIL reset_data: got addr=%h instr=%h npc=%h required 0 0 0", imem_addr, out_instr, out_npc);
        end
        rst_n = 1'b1;
        @(negedge clk1);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
            n_fail++; $display("FAIL startup_req: got req=%b addr=%h required 1 000", imem_req, imem_addr);
        end
        $display("test_reset done");
    endtask

    task automatic test_straight();
        exp_t e;
        int first;
        out_ready = 1'b1;
        apply_reset();
        for (int a = 0; a < 8; a++) push_exp(a);
        first = -1;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            if (out_valid && first < 0) first = cyc;
            if (first >= 0 && cyc < first + 8) begin
                n_checks++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL straight_stream: cycle %0d valid=%b required 1", cyc, out_valid); end
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out_instr !== e.instr || out_npc !== e.npc) begin
                    n_fail++; $display("FAIL straight_xfer: got %h/%h required %h/%h", out_instr, out_npc, e.instr, e.npc);
                end else $display("straight xfer npc=%h instr=%h", out_npc, out_instr);
            end
            @(negedge clk1);
        end
        n_checks++;
        if (first != LAT + 1) begin n_fail++; $display("FAIL straight_latency: first valid cycle %0d required %0d", first, LAT + 1); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL straight_drain: %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int nreq;
        out_ready = 1'b0;
        apply_reset();
        nreq = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (imem_req) nreq++;
            @(negedge clk1);
        end
        n_checks++;
        if (nreq != DEPTH) begin n_fail++; $display("FAIL bp_reqs: got %0d required %0d", nreq, DEPTH); end
        n_checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_full: got req=%b valid=%b required 0 1", imem_req, out_valid);
        end
        for (int a = 0; a < 5; a++) push_exp(a);
        out_ready = 1'b1;
        for (int k = 0; k < 12 && exp_q.size() > 0; k++) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out_instr !== e.instr || out_npc !== e.npc) begin
                    n_fail++; $display("FAIL bp_xfer: got %h/%h required %h/%h", out_instr, out_npc, e.instr, e.npc);
                end else $display("bp xfer npc=%h instr=%h", out_npc, out_instr);
            end
            @(negedge clk1);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        exp_t e;
        bit found;
        int first;
        out_ready = 1'b1;
        apply_reset();
        for (int a = 0; a < 5; a++) push_exp(a);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (imem_req && imem_addr == 10'd5) found = 1;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out_instr !== e.instr || out_npc !== e.npc) begin
                    n_fail++; $display("FAIL redir_pre_xfer: got %h/%h required %h/%h", out_instr, out_npc, e.instr, e.npc);
                end
            end
            @(negedge clk1);
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL redir_find5: request for address 5 not seen, required within 20 cycles"); end
        // Address 5 is in flight now; anything still queued is flushed.
        exp_q.delete();
        redirect_valid = 1'b1;
        redirect_pc = 10'h100;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL redir_cycle: got valid=%b req=%b required 0 0", out_valid, imem_req);
        end
        for (int a = 'h100; a < 'h103; a++) push_exp(a);
        @(negedge clk1);
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h100) begin
            n_fail++; $display("FAIL redir_req: got req=%b addr=%h required 1 100", imem_req, imem_addr);
        end
        first = -1;
        for (int c = 1; c <= 10; c++) begin
            if (out_valid && first < 0) first = c;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out_instr !== e.instr || out_npc !== e.npc) begin
                    n_fail++; $display("FAIL redir_xfer: got %h/%h required %h/%h", out_instr, out_npc, e.instr, e.npc);
                end else $display("redirect xfer npc=%h instr=%h", out_npc, out_instr);
            end
            @(negedge clk1);
        end
        n_checks++;
        if (first != LAT + 1) begin n_fail++; $display("FAIL redir_latency: first valid R+%0d required R+%0d", first, LAT + 1); end
    endtask

    task automatic test_park_unpark();
        exp_t e;
        int nreq;
        mem[3] = 32'h8000_0000;
        out_ready = 1'b1;
        apply_reset();
        for (int a = 0; a < 5; a++) push_exp(a);
        nreq = 0;
        for (int k = 0; k < 15; k++) begin
            if (imem_req) nreq++;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL park_extra: got npc=%h required no transfer", out_npc);
                end else begin
                    e = exp_q.pop_front();
                    if (out_instr !== e.instr || out_npc !== e.npc) begin
                        n_fail++; $display("FAIL park_xfer: got %h/%h required %h/%h", out_instr, out_npc, e.instr, e.npc);
                    end else $display("park xfer npc=%h instr=%h", out_npc, out_instr);
                end
            end
            @(negedge clk1);
        end
        n_checks++;
        if (nreq != 5) begin n_fail++; $display("FAIL park_reqs: got %0d required 5", nreq); end
        n_checks++;
        if (fetch_parked !== 1'b1 || imem_req !== 1'b0) begin
            n_fail++; $display("FAIL park_state: got parked=%b req=%b required 1 0", fetch_parked, imem_req);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL park_drain: %0d left required 0", exp_q.size()); end
        // Unpark via redirect.
        redirect_valid = 1'b1;
        redirect_pc = 10'h020;
        for (int a = 'h20; a < 'h23; a++) push_exp(a);
        @(negedge clk1);
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (fetch_parked !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 10'h020) begin
            n_fail++; $display("FAIL unpark: got parked=%b req=%b addr=%h required 0 1 020", fetch_parked, imem_req, imem_addr);
        end
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out_instr !== e.instr || out_npc !== e.npc) begin
                    n_fail++; $display("FAIL unpark_xfer: got %h/%h required %h/%h", out_instr, out_npc, e.instr, e.npc);
                end else $display("unpark xfer npc=%h instr=%h", out_npc, out_instr);
            end
            @(negedge clk1);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL unpark_drain: %0d left required 0", exp_q.size()); end
        fill_mem();
    endtask

    task automatic test_wrap();
        exp_t e;
        out_ready = 1'b1;
        apply_reset();
        redirect_valid = 1'b1;
        redirect_pc = 10'h3FF;
        push_exp('h3FF);
        push_exp('h000);
        push_exp('h001);
        @(negedge clk1);
        redirect_valid = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h3FF) begin
            n_fail++; $display("FAIL wrap_req0: got req=%b addr=%h required 1 3ff", imem_req, imem_addr);
        end
        @(negedge clk1);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
            n_fail++; $display("FAIL wrap_req1: got req=%b addr=%h required 1 000", imem_req, imem_addr);
        end
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out_instr !== e.instr || out_npc !== e.npc) begin
                    n_fail++; $display("FAIL wrap_xfer: got %h/%h required %h/%h", out_instr, out_npc, e.instr, e.npc);
                end else $display("wrap xfer npc=%h instr=%h", out_npc, out_instr);
            end
            @(negedge clk1);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_drain: %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        out_ready = 1'b1;
        apply_reset();
        repeat (6) @(negedge clk1);
        @(posedge clk1);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0 || fetch_parked !== 1'b0 || imem_addr !== 10'h000
            || out_instr !== 32'h0 || out_npc !== 10'h000) begin
            n_fail++; $display("FAIL midreset_outputs: got req=%b valid=%b parked=%b addr=%h instr=%h npc=%h required all 0",
                               imem_req, out_valid, fetch_parked, imem_addr, out_instr, out_npc);
        end
        exp_q.delete();
        @(negedge clk1);
        rst_n = 1'b1;
        for (int a = 0; a < 3; a++) push_exp(a);
        @(negedge clk1);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 10'h000) begin
            n_fail++; $display("FAIL midreset_restart: got req=%b addr=%h required 1 000", imem_req, imem_addr);
        end
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out_instr !== e.instr || out_npc !== e.npc) begin
                    n_fail++; $display("FAIL midreset_xfer: got %h/%h required %h/%h", out_instr, out_npc, e.instr, e.npc);
                end else $display("midreset xfer npc=%h instr=%h", out_npc, out_instr);
            end
            @(negedge clk1);
        end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL midreset_drain: %0d left required 0", exp_q.size()); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;
        fill_mem();
        test_reset();
        test_straight();
        test_backpressure();
        test_redirect();
        test_park_unpark();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
